mc_state_ctrl: RTL
==================

# mc_state_ctrl

Sequencing core of the memory controller: accepts single read/write requests from the CPU datapath, latches address and write data, and steps through IDLE → ACTIVE → READ/WRITE → IDLE with a parameterised per-operation latency. Its `currentState` output drives the downstream memory-controller output decoder, which turns it into `mem_read`, `mem_write`, `active` and `status`. It also returns captured read data and a one-cycle completion pulse to the requester.

## Interface
- `ADDR_WIDTH`, 32, width of request/latched address
- `DATA_WIDTH`, 32, width of write/read data
- `READ_LATENCY`, 4, cycles spent in READ (legal range 1–255)
- `WRITE_LATENCY`, 3, cycles spent in WRITE (legal range 1–255)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_read`  in  1  read request, sampled only in IDLE
- `req_write`  in  1  write request, sampled only in IDLE
- `req_addr`  in  ADDR_WIDTH  request address
- `req_wdata`  in  DATA_WIDTH  write data
- `mem_rdata`  in  DATA_WIDTH  memory read data
- `currentState`  out  2  00 IDLE, 01 ACTIVE, 10 READ, 11 WRITE
- `addr_q`  out  ADDR_WIDTH  latched address presented to memory
- `wdata_q`  out  DATA_WIDTH  latched write data
- `rdata_q`  out  DATA_WIDTH  captured read data
- `busy`  out  1  high whenever `currentState` ≠ IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- Registered state; encoding fixed as above, because the downstream decoder depends on it.
- IDLE: if `req_write` = 1, latch `req_addr` and `req_wdata`, set op = write, go to ACTIVE. Else if `req_read` = 1, latch `req_addr`, set op = read, go to ACTIVE. Else stay.
- Both requests high in IDLE: write wins. The read is dropped and must be re-asserted.
- Requests while `busy` = 1 are ignored (not queued). `addr_q` and `wdata_q` hold during the whole operation.
- ACTIVE: lasts exactly 1 cycle. It loads the down-counter with LATENCY−1 for the latched op, then goes to READ or WRITE.
- READ/WRITE: the counter decrements every cycle. When the counter is 0, the next state is IDLE.
- On the final READ cycle (counter = 0), `rdata_q` ← `mem_rdata`.
- `done` is registered and is high only during the first IDLE cycle after READ/WRITE.
- `rdata_q` holds its value until the next read completes. Writes do not change it.
- The counter is 8 bits, unsigned, and never underflows (it is only decremented when non-zero).
- Reset: all outputs go to 0 immediately: `currentState` = 00, `addr_q` = `wdata_q` = `rdata_q` = 0, `busy` = `done` = 0, counter = 0. An in-flight operation is abandoned; no `done` is produced for it.
- After reset release, the first rising edge samples requests normally.

## Timing
- Request sampled at edge E0 (state IDLE) → ACTIVE in cycle 1.
- READ occupies cycles 2 .. READ_LATENCY+1. IDLE with `done` = 1 and valid `rdata_q` is at cycle READ_LATENCY+2.
- WRITE is the same, using WRITE_LATENCY.
- Total request-to-`done` latency is LATENCY+2 cycles.
- Back-to-back: a request held high during the `done` cycle is accepted at that edge. The minimum issue interval is therefore LATENCY+2 cycles.
- `busy` rises in the cycle after acceptance and falls in the same cycle `done` rises.
- `mem_rdata` must be stable at the edge ending the last READ cycle. No other cycle samples it.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs → all outputs 0 and `currentState` = 00. Release, no requests → stays IDLE, `done` = 0.
- Read, READ_LATENCY = 4: `req_read` = 1, `req_addr` = 0x0000_1000, `mem_rdata` = 0xDEAD_BEEF on the last READ cycle. Expect:
  - `currentState` sequence 00, 01, 10, 10, 10, 10, 00
  - `done` = 1 and `rdata_q` = 0xDEAD_BEEF in cycle 6
  - `addr_q` = 0x1000 throughout
- Write, WRITE_LATENCY = 3: `req_write` = 1, `req_addr` = 0x20, `req_wdata` = 0x1234_5678. Expect:
  - `currentState` sequence 00, 01, 11, 11, 11, 00
  - `wdata_q` = 0x1234_5678 throughout
  - `done` pulse at cycle 5
  - `rdata_q` unchanged
- Simultaneous `req_read` = `req_write` = 1 in IDLE → WRITE path taken, no read performed.
- Requests during busy: pulse `req_read` in every READ cycle → ignored, a single `done`. Hold `req_write` through the `done` cycle → accepted, ACTIVE on the next cycle.
- Reset mid-operation: assert `rst_n` = 0 asynchronously mid-READ → outputs 0 before the next edge. After release, state is IDLE and no `done` pulse appears.

Source files
------------

// File: rtl/mc_state_ctrl.sv
// Memory-controller sequencing core: accepts one read/write request in IDLE, latches it,
// and walks IDLE -> ACTIVE -> READ/WRITE -> IDLE with a per-operation latency.
module mc_state_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            currentState,
  output logic [ADDR_WIDTH-1:0] addr_q,
  output logic [DATA_WIDTH-1:0] wdata_q,
  output logic [DATA_WIDTH-1:0] rdata_q,
  output logic                  busy,
  output logic                  done
);

  // Encoding is consumed by the downstream output decoder and must not change.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_READ   = 2'b10,
    ST_WRITE  = 2'b11
  } state_e;

  localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

  state_e                  state_q, state_d;
  logic                    op_write_q, op_write_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Next-state and datapath updates for the request sequencer.
  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_write) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          op_write_d = 1'b1;
          state_d    = ST_ACTIVE;
        end else if (req_read) begin
          addr_d     = req_addr;
          op_write_d = 1'b0;
          state_d    = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (op_write_q) begin
          cnt_d   = WR_LOAD;
          state_d = ST_WRITE;
        end else begin
          cnt_d   = RD_LOAD;
          state_d = ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        // Counter only decrements while non-zero; zero marks the final data cycle.
        if (cnt_q == 8'd0) begin
          if (state_q == ST_READ) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_write_q <= 1'b0;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign currentState = state_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
